// File: rtl/irq_pending_pkg.sv
// Shared definitions for the interrupt pending block.
//   IRQ_N      : number of request lines (fixed by the 8-to-3 encoder stage)
//   IRQ_IDX_W  : width of an acknowledge index
//   irq_state_e: request FSM states
package irq_pending_pkg;
  localparam int IRQ_N     = 8;
  localparam int IRQ_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_pending_sync2.sv
// Two-flop synchronizer for a bundle of independent asynchronous levels.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both stages
//   d     : asynchronous inputs
//   q     : synchronized outputs (two cycles of latency)
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/irq_pending.sv
// Edge-detecting interrupt pending register with a single request line to
// the consumer.
//   clk       : clock
//   rst_n     : async active-low reset
//   req       : asynchronous level request lines (rising edge = event)
//   mask      : per-line enable, 1 = enabled
//   ack_valid : one-cycle acknowledge strobe
//   ack_idx   : line to clear, sampled with ack_valid
//   pend      : raw pending bits AND mask
//   irq       : registered request, high only in ASSERT
//   ack_err   : one-cycle pulse after an acknowledge that cleared nothing
module irq_pending
  import irq_pending_pkg::*;
#(
  parameter int N = IRQ_N  // only 8 is supported
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic                 ack_valid,
  input  logic [IRQ_IDX_W-1:0] ack_idx,
  output logic [N-1:0]         pend,
  output logic                 irq,
  output logic                 ack_err
);
  logic [N-1:0] sync_q, delay_q, rise, raw_q, clr;
  logic [2:0]   vld_pipe;
  logic         ack_ok;
  irq_state_e   state_q, state_d;

  sync2 #(.W(N)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req),
    .q    (sync_q)
  );

  // The synchronizer and delay flops come out of reset low, so a line that
  // is already high at release would look like a rise. vld_pipe counts the
  // first three edges after release; by then delay_q has caught up with
  // sync_q, and edge detection is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q  <= '0;
      vld_pipe <= '0;
    end else begin
      delay_q  <= sync_q;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign rise = sync_q & ~delay_q & {N{vld_pipe[2]}};
  assign pend = raw_q & mask;

  // An acknowledge only counts in ASSERT and for a line that is visible.
  assign ack_ok = ack_valid && (state_q == ASSERT) && pend[ack_idx];

  always_comb begin
    clr = '0;
    if (ack_ok) clr[ack_idx] = 1'b1;
  end

  // Set after clear: a coincident rise on the acknowledged line wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raw_q <= '0;
    else        raw_q <= (raw_q & ~clr) | rise;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend != '0) state_d = ASSERT;
      ASSERT:  if (ack_valid)       state_d = HOLDOFF;
               else if (pend == '0) state_d = IDLE;
      HOLDOFF: state_d = IDLE;  // forces a low gap on irq
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq     <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state_q <= state_d;
      irq     <= (state_d == ASSERT);
      ack_err <= ack_valid && !ack_ok;
    end
  end
endmodule

// File: tb/tb_irq_pending.sv
module tb_irq_pending;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask, pend;
  logic       ack_valid, irq, ack_err;
  logic [2:0] ack_idx;
  int checks = 0;
  int errors = 0;

  irq_pending dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .ack_valid(ack_valid),
    .ack_idx  (ack_idx),
    .pend     (pend),
    .irq      (irq),
    .ack_err  (ack_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; mask = 8'hFF; ack_valid = 1'b0; ack_idx = 3'd0;
    tick(2);
    chk("rst_pend", pend, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_ack_err", {7'b0, ack_err}, 8'h00);
    rst_n = 1'b1;
    tick(4);

    // rise then acknowledge
    req = 8'h04;
    tick(2);
    chk("s1_pend_t1", pend, 8'h00);
    tick(1);
    chk("s1_pend_t2", pend, 8'h04);
    chk("s1_irq_t2", {7'b0, irq}, 8'h00);
    tick(1);
    chk("s1_irq_t3", {7'b0, irq}, 8'h01);
    ack_valid = 1'b1; ack_idx = 3'd2;
    tick(1);
    ack_valid = 1'b0;
    chk("s1_pend_ack", pend, 8'h00);
    chk("s1_irq_ack", {7'b0, irq}, 8'h00);
    chk("s1_noerr", {7'b0, ack_err}, 8'h00);
    tick(1);
    chk("s1_irq_gap", {7'b0, irq}, 8'h00);
    req = 8'h00;
    tick(4);

    // masked latch
    mask = 8'h00; req = 8'h81;
    tick(5);
    chk("s2_pend_masked", pend, 8'h00);
    chk("s2_irq_masked", {7'b0, irq}, 8'h00);
    mask = 8'h80;
    #1;
    chk("s2_pend_unmask", pend, 8'h80);
    tick(1);
    chk("s2_irq_unmask", {7'b0, irq}, 8'h01);
    ack_valid = 1'b1; ack_idx = 3'd7;
    tick(1);
    ack_valid = 1'b0;
    chk("s2_pend_ack7", pend, 8'h00);
    mask = 8'hFF;
    #1;
    chk("s2_pend_bit0", pend, 8'h01);
    tick(2);
    chk("s2_irq_bit0", {7'b0, irq}, 8'h01);
    ack_valid = 1'b1; ack_idx = 3'd0;
    tick(1);
    ack_valid = 1'b0;
    chk("s2_pend_clr", pend, 8'h00);
    req = 8'h00;
    tick(4);

    // bad acknowledge
    req = 8'h10;
    tick(4);
    chk("s3_pend", pend, 8'h10);
    chk("s3_irq", {7'b0, irq}, 8'h01);
    ack_valid = 1'b1; ack_idx = 3'd3;
    tick(1);
    ack_valid = 1'b0;
    chk("s3_ack_err", {7'b0, ack_err}, 8'h01);
    chk("s3_pend_kept", pend, 8'h10);
    chk("s3_irq_holdoff", {7'b0, irq}, 8'h00);
    tick(1);
    chk("s3_ack_err_end", {7'b0, ack_err}, 8'h00);
    chk("s3_irq_idle", {7'b0, irq}, 8'h00);
    tick(1);
    chk("s3_irq_again", {7'b0, irq}, 8'h01);
    ack_valid = 1'b1; ack_idx = 3'd4;
    tick(1);
    chk("s3_pend_clr", pend, 8'h00);
    chk("s3_good_noerr", {7'b0, ack_err}, 8'h00);
    ack_idx = 3'd4;  // strobe held into HOLDOFF: invalid
    tick(1);
    ack_valid = 1'b0;
    chk("s3_holdoff_err", {7'b0, ack_err}, 8'h01);
    req = 8'h00;
    tick(4);

    // set beats clear
    req = 8'h20;
    tick(4);
    chk("s4_irq", {7'b0, irq}, 8'h01);
    req = 8'h00;
    tick(3);
    req = 8'h20;
    tick(2);
    ack_valid = 1'b1; ack_idx = 3'd5;
    tick(1);
    ack_valid = 1'b0;
    chk("s4_pend_set_wins", pend, 8'h20);
    chk("s4_irq_holdoff", {7'b0, irq}, 8'h00);
    chk("s4_noerr", {7'b0, ack_err}, 8'h00);
    tick(1);
    chk("s4_irq_idle", {7'b0, irq}, 8'h00);
    tick(1);
    chk("s4_irq_reassert", {7'b0, irq}, 8'h01);

    // reset corner with all lines high
    req = 8'hFF;
    tick(4);
    chk("s5_pend_all", pend, 8'hFF);
    chk("s5_irq", {7'b0, irq}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_pend_async", pend, 8'h00);
    chk("s5_irq_async", {7'b0, irq}, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    chk("s5_pend_after", pend, 8'h00);
    chk("s5_irq_after", {7'b0, irq}, 8'h00);

    // rise on one line with clear of another, then masking drops ASSERT
    req = 8'h00;
    tick(4);
    req = 8'h01;
    tick(4);
    chk("s6_irq", {7'b0, irq}, 8'h01);
    req = 8'h03;
    tick(2);
    ack_valid = 1'b1; ack_idx = 3'd0;
    tick(1);
    ack_valid = 1'b0;
    chk("s6_pend_both", pend, 8'h02);
    tick(2);
    chk("s6_irq_bit1", {7'b0, irq}, 8'h01);
    mask = 8'h00;
    tick(1);
    chk("s6_irq_masked_off", {7'b0, irq}, 8'h00);
    chk("s6_pend_masked", pend, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
